// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle for the iterative RV32M multiply/divide unit.
// Signal names follow the unit's original port list.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic             i_flush;
    logic             o_valid;
    logic             i_result_ready;
    logic [WIDTH-1:0] o_result;

    modport master (
        output i_valid, i_op, i_op_a, i_op_b, i_flush, i_result_ready,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_op, i_op_a, i_op_b, i_flush, i_result_ready,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring
// divide, magnitude datapath with a final sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic          i_clk,
    input logic          i_rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;

    logic               a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_sel;

    always_comb begin
        a_neg    = bus.i_op_a[WIDTH-1] &
                   ((bus.i_op == 3'd1) | (bus.i_op == 3'd2) | (bus.i_op == 3'd4) | (bus.i_op == 3'd6));
        b_neg    = bus.i_op_b[WIDTH-1] &
                   ((bus.i_op == 3'd1) | (bus.i_op == 3'd4) | (bus.i_op == 3'd6));
        // MIN negates to itself, which is exactly its unsigned magnitude
        mag_a    = a_neg ? -bus.i_op_a : bus.i_op_a;
        mag_b    = b_neg ? -bus.i_op_b : bus.i_op_b;
        div_zero = bus.i_op[2] & (bus.i_op_b == '0);
        div_ovf  = bus.i_op[2] & ~bus.i_op[0] & (bus.i_op_a == MIN_VAL) & (bus.i_op_b == '1);
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvs_q : '0)};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, dvs_q};
        rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, dvs_q}) : div_shift[WIDTH-1:0];
        prod_fix  = neg_q ? -acc_q : acc_q;
        div_sel   = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && !bus.i_flush) begin
                    op_d  = bus.i_op;
                    neg_d = (bus.i_op[2] & bus.i_op[1]) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero) begin
                        result_d = bus.i_op[1] ? bus.i_op_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.i_op[1] ? '0 : MIN_VAL;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, (bus.i_op[2] ? mag_a : mag_b)};
                        dvs_d   = bus.i_op[2] ? mag_b : mag_a;
                        state_d = bus.i_op[2] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                // upper half holds the partial remainder, lower half shifts dividend out / quotient in
                acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[2])
                    result_d = neg_q ? -div_sel : div_sel;
                else
                    result_d = (op_q == 3'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (valid_q && bus.i_result_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.i_flush && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_ready  = (state_q == S_IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    muldiv_unit_if #(.WIDTH(32)) bus32 ();
    muldiv_unit_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32.slave));
    muldiv_unit #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit w8, input logic v, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.i_valid = v; bus8.i_op = op; bus8.i_op_a = a[7:0]; bus8.i_op_b = b[7:0];
        end else begin
            bus32.i_valid = v; bus32.i_op = op; bus32.i_op_a = a; bus32.i_op_b = b;
        end
    endtask

    task automatic set_rr(input bit w8, input logic v);
        if (w8) bus8.i_result_ready = v;
        else    bus32.i_result_ready = v;
    endtask

    task automatic sample(input bit w8, output logic rdy, output logic vld, output logic [31:0] res);
        if (w8) begin
            rdy = bus8.o_ready; vld = bus8.o_valid; res = {24'h0, bus8.o_result};
        end else begin
            rdy = bus32.o_ready; vld = bus32.o_valid; res = bus32.o_result;
        end
    endtask

    // Accepts one op, keeps junk requests asserted while busy, measures latency, hands off.
    task automatic run_op(input string tag, input bit w8, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        logic        rdy, vld;
        logic [31:0] res;
        int          edges;
        sample(w8, rdy, vld, res);
        check({tag, " ready"}, 64'(rdy), 64'd1);
        drive_req(w8, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive_req(w8, 1'b1, 3'd7, 32'hA5A5A5A5, 32'h5A5A5A5A);
        edges = 0;
        sample(w8, rdy, vld, res);
        while (!vld && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            sample(w8, rdy, vld, res);
        end
        drive_req(w8, 1'b0, 3'd0, 32'h0, 32'h0);
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check({tag, " result"}, 64'(res), 64'(exp_res));
        set_rr(w8, 1'b1);
        @(posedge clk); #1;
        set_rr(w8, 1'b0);
        sample(w8, rdy, vld, res);
        check({tag, " valid after handoff"}, 64'(vld), 64'd0);
        check({tag, " ready after handoff"}, 64'(rdy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rdy, vld;
        logic [31:0] res;
        bit          seen;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        bus32.i_flush = 1'b0; bus8.i_flush = 1'b0;
        set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        sample(1'b0, rdy, vld, res);
        check("reset ready", 64'(rdy), 64'd1);
        check("reset valid", 64'(vld), 64'd0);
        check("reset result", 64'(res), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("MUL 7*-3",        1'b0, 3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run_op("MULH 7*-3",       1'b0, 3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_op("MULHU 7*FFFFFFFD", 1'b0, 3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 34);
        run_op("MULHSU -1*FFFFFFFF", 1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("MULH MIN*MIN",    1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("DIV -7/2",        1'b0, 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34);
        run_op("REM -7/2",        1'b0, 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34);
        run_op("DIVU 100/7",      1'b0, 3'd5, 32'd100,      32'd7,        32'd14,       34);
        run_op("REMU 100/7",      1'b0, 3'd7, 32'd100,      32'd7,        32'd2,        34);
        run_op("DIV 5/0",         1'b0, 3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REMU 5/0",        1'b0, 3'd7, 32'd5,        32'd0,        32'd5,        1);
        run_op("DIV MIN/-1",      1'b0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM MIN/-1",      1'b0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // flush while idle must block the request
        drive_req(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
        bus32.i_flush = 1'b1;
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus32.i_flush = 1'b0;
        sample(1'b0, rdy, vld, res);
        check("idle flush blocks accept", 64'(rdy), 64'd1);

        // back-pressure
        drive_req(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 100 && !bus32.o_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            sample(1'b0, rdy, vld, res);
            check("backpressure valid", 64'(vld), 64'd1);
            check("backpressure result", 64'(res), 64'd12);
            check("backpressure ready", 64'(rdy), 64'd0);
            @(posedge clk); #1;
        end
        set_rr(1'b0, 1'b1);
        @(posedge clk); #1;
        set_rr(1'b0, 1'b0);
        sample(1'b0, rdy, vld, res);
        check("backpressure release valid", 64'(vld), 64'd0);
        check("backpressure release ready", 64'(rdy), 64'd1);

        // flush during the 10th DIV iteration
        drive_req(1'b0, 1'b1, 3'd5, 32'd100, 32'd7);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        bus32.i_flush = 1'b1;
        @(posedge clk); #1;
        bus32.i_flush = 1'b0;
        sample(1'b0, rdy, vld, res);
        check("flush returns idle", 64'(rdy), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.o_valid) seen = 1'b1;
        end
        check("flush no result", 64'(seen), 64'd0);
        run_op("MUL 3*4 after flush", 1'b0, 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // asynchronous reset in the middle of a multiply
        drive_req(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sample(1'b0, rdy, vld, res);
        check("async reset ready", 64'(rdy), 64'd1);
        check("async reset valid", 64'(vld), 64'd0);
        check("async reset result", 64'(res), 64'd0);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.o_valid) seen = 1'b1;
        end
        check("reset no result", 64'(seen), 64'd0);
        run_op("MUL 3*4 after reset", 1'b0, 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // WIDTH=8 instance
        run_op("W8 MUL 3*4",    1'b1, 3'd0, 32'h03, 32'h04, 32'h0C, 10);
        run_op("W8 DIV 80/FF",  1'b1, 3'd4, 32'h80, 32'hFF, 32'h80, 1);
        run_op("W8 DIVU 80/FF", 1'b1, 3'd5, 32'h80, 32'hFF, 32'h00, 10);
        run_op("W8 DIV 80/02",  1'b1, 3'd4, 32'h80, 32'h02, 32'hC0, 10);
        run_op("W8 MULH 80*80", 1'b1, 3'd1, 32'h80, 32'h80, 32'h40, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
